imu_frame_packer: RTL and testbench

//  Sink end of the IMU sample stream. Captures one signed ax/ay/az triple per

---
 rtl/imu_pkg.sv | 28 ++
 rtl/imu_frame_packer.sv | 173 +++++++++++++++++
 tb/tb_imu_frame_packer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imu_pkg.sv
// imu_pkg
//   Shared definitions for the IMU frame packer: frame geometry, FSM state
//   encoding, byte index constants and default sync header bytes.
package imu_pkg;

  localparam int FRAME_LEN = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Byte positions inside a frame.
  localparam logic [3:0] IDX_SYNC0 = 4'd0;
  localparam logic [3:0] IDX_SYNC1 = 4'd1;
  localparam logic [3:0] IDX_SEQ   = 4'd2;
  localparam logic [3:0] IDX_AX_HI = 4'd3;
  localparam logic [3:0] IDX_AX_LO = 4'd4;
  localparam logic [3:0] IDX_AY_HI = 4'd5;
  localparam logic [3:0] IDX_AY_LO = 4'd6;
  localparam logic [3:0] IDX_AZ_HI = 4'd7;
  localparam logic [3:0] IDX_AZ_LO = 4'd8;
  localparam logic [3:0] IDX_CHK   = 4'(FRAME_LEN - 1);

  localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;

endpackage

// File: rtl/imu_frame_packer.sv
// imu_frame_packer
//   Captures one signed ax/ay/az triple per sample strobe, packs it into a
//   10-byte frame (SYNC0, SYNC1, seq, ax_hi, ax_lo, ay_hi, ay_lo, az_hi, az_lo,
//   chk) and streams it out one byte at a time over valid/ready.
//   chk is the XOR of bytes seq..az_lo.
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   sample_valid   1-cycle strobe qualifying ax/ay/az
//   ax, ay, az     signed WIDTH-bit samples, sign-extended to 16 bits
//   out_data       current frame byte (registered)
//   out_valid      out_data valid (registered)
//   out_ready      downstream accept
//   busy           a frame is in progress; a strobe now would be dropped
//   drop_cnt       saturating count of dropped samples
module imu_frame_packer
  import imu_pkg::*;
#(
  parameter int         WIDTH = 16,
  parameter logic [7:0] SYNC0 = SYNC0_DEFAULT,
  parameter logic [7:0] SYNC1 = SYNC1_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic signed [WIDTH-1:0] ax,
  input  logic signed [WIDTH-1:0] ay,
  input  logic signed [WIDTH-1:0] az,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic [7:0]              drop_cnt
);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  out_data_d;
  logic        out_valid_d;
  logic [15:0] ax_q, ay_q, az_q;

  logic        accept;
  logic        last_accept;
  logic        capture;
  logic        drop;
  logic [3:0]  idx_adv;
  logic [7:0]  chk_next;
  logic [7:0]  byte_nxt;
  logic        in_chk_span;

  // Signed size casts sign-extend narrow samples into the 16-bit frame fields.
  logic signed [15:0] ax_ext, ay_ext, az_ext;
  assign ax_ext = 16'(ax);
  assign ay_ext = 16'(ay);
  assign az_ext = 16'(az);

  assign accept      = out_valid && out_ready;
  assign last_accept = accept && (idx_q == IDX_CHK);
  // A strobe is taken when idle, or in the very cycle the checksum leaves,
  // so back-to-back frames run without a gap.
  assign capture     = sample_valid && ((state_q == ST_IDLE) || last_accept);
  assign drop        = sample_valid && !capture;
  assign idx_adv     = idx_q + 4'd1;
  assign in_chk_span = (idx_q >= IDX_SEQ) && (idx_q <= IDX_AZ_LO);
  // Running checksum including the byte currently on the bus.
  assign chk_next    = chk_q ^ out_data;
  assign busy        = (state_q == ST_SEND);

  // Byte that follows the one being accepted.
  always_comb begin
    byte_nxt = 8'h00;
    case (idx_adv)
      IDX_SYNC0: byte_nxt = SYNC0;
      IDX_SYNC1: byte_nxt = SYNC1;
      IDX_SEQ:   byte_nxt = seq_q;
      IDX_AX_HI: byte_nxt = ax_q[15:8];
      IDX_AX_LO: byte_nxt = ax_q[7:0];
      IDX_AY_HI: byte_nxt = ay_q[15:8];
      IDX_AY_LO: byte_nxt = ay_q[7:0];
      IDX_AZ_HI: byte_nxt = az_q[15:8];
      IDX_AZ_LO: byte_nxt = az_q[7:0];
      IDX_CHK:   byte_nxt = chk_next;
      default:   byte_nxt = 8'h00;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    seq_d       = seq_q;
    chk_d       = chk_q;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          state_d     = ST_SEND;
          idx_d       = IDX_SYNC0;
          chk_d       = 8'h00;
          out_data_d  = SYNC0;
          out_valid_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (accept) begin
          if (in_chk_span) chk_d = chk_next;
          if (idx_q == IDX_CHK) begin
            seq_d = seq_q + 8'd1;
            idx_d = IDX_SYNC0;
            if (capture) begin
              chk_d      = 8'h00;
              out_data_d = SYNC0;
            end else begin
              state_d     = ST_IDLE;
              out_valid_d = 1'b0;
            end
          end else begin
            idx_d      = idx_adv;
            out_data_d = byte_nxt;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= IDX_SYNC0;
      seq_q     <= 8'h00;
      chk_q     <= 8'h00;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seq_q     <= seq_d;
      chk_q     <= chk_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ax_q <= 16'h0000;
      ay_q <= 16'h0000;
      az_q <= 16'h0000;
    end else if (capture) begin
      ax_q <= ax_ext;
      ay_q <= ay_ext;
      az_q <= az_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 8'h00;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_imu_frame_packer.sv
// tb_imu_frame_packer
//   Self-checking bench: a queue-based frame model predicts every byte,
//   out_valid, busy and drop_cnt; directed scenarios add literal expectations.
module tb_imu_frame_packer;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sample_valid = 1'b0;
  logic signed [15:0] ax = '0, ay = '0, az = '0;
  logic [7:0]         out_data;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               busy;
  logic [7:0]         drop_cnt;

  logic               sv12 = 1'b0;
  logic signed [11:0] ax12 = '0, ay12 = '0, az12 = '0;
  logic [7:0]         out_data12;
  logic               out_valid12;
  logic               ready12 = 1'b1;
  logic               busy12;
  logic [7:0]         drop_cnt12;

  always #5 clk = ~clk;

  imu_frame_packer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .ax(ax), .ay(ay), .az(az),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  imu_frame_packer #(.WIDTH(12)) dut12 (
    .clk(clk), .rst(rst), .sample_valid(sv12),
    .ax(ax12), .ay(ay12), .az(az12),
    .out_data(out_data12), .out_valid(out_valid12), .out_ready(ready12),
    .busy(busy12), .drop_cnt(drop_cnt12)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [7:0] b;
    logic [3:0] idx;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] acc_log[$];
  logic [7:0] seq_log[$];
  logic [7:0] log12[$];
  int         m_seq  = 0;
  int         m_drop = 0;

  function automatic logic [9:0][7:0] build_frame(input logic [15:0] a, b, c,
                                                  input logic [7:0] s);
    logic [9:0][7:0] f;
    f[0] = 8'hA5; f[1] = 8'h5A; f[2] = s;
    f[3] = a[15:8]; f[4] = a[7:0];
    f[5] = b[15:8]; f[6] = b[7:0];
    f[7] = c[15:8]; f[8] = c[7:0];
    f[9] = f[2] ^ f[3] ^ f[4] ^ f[5] ^ f[6] ^ f[7] ^ f[8];
    return f;
  endfunction

  // Compare on the falling edge, then fold in the inputs that the next
  // rising edge will see.
  always @(negedge clk) begin
    int  sz;
    bit  acc;
    bit  last;
    logic [9:0][7:0] f;
    if (rst) begin
      exp_q.delete();
      m_seq  = 0;
      m_drop = 0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
    end else begin
      sz = exp_q.size();
      check("out_valid", 32'(out_valid), 32'(sz != 0));
      check("busy", 32'(busy), 32'(sz != 0));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (sz != 0) check("out_data", 32'(out_data), 32'(exp_q[0].b));
      acc  = (sz != 0) && out_ready;
      last = acc && (sz == 1);
      if (acc) begin
        acc_log.push_back(exp_q[0].b);
        if (exp_q[0].idx == 4'd2) seq_log.push_back(exp_q[0].b);
        void'(exp_q.pop_front());
      end
      if (sample_valid) begin
        if (sz == 0 || last) begin
          f = build_frame(ax, ay, az, 8'(m_seq));
          m_seq = (m_seq + 1) % 256;
          for (int k = 0; k < 10; k++) exp_q.push_back('{b: f[k], idx: 4'(k)});
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid12 && ready12) log12.push_back(out_data12);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] a, b, c);
    sample_valid = 1'b1;
    ax = a; ay = b; az = c;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    check("idle_reached", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_front(input logic [3:0] idx);
    int i;
    for (i = 0; i < 50 && !(exp_q.size() != 0 && exp_q[0].idx == idx); i++) tick();
    check("front_reached", 32'(i < 50), 32'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  logic [7:0] t1_exp[10]  = '{8'hA5, 8'h5A, 8'h00, 8'h12, 8'h34, 8'hFF, 8'h00, 8'h00, 8'h01, 8'hD8};
  logic [7:0] t12_exp[10] = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'hFF, 8'h07, 8'hFF, 8'hF8, 8'h00, 8'h00};

  task automatic check_log_t1(input string name);
    check({name, "_len"}, 32'(acc_log.size()), 32'd10);
    for (int k = 0; k < 10 && k < acc_log.size(); k++)
      check(name, 32'(acc_log[k]), 32'(t1_exp[k]));
  endtask

  initial begin
    logic [9:0][7:0] pin;
    #100ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0][7:0] pin;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    // Pin the model itself against a hand-computed checksum.
    pin = build_frame(16'h1234, 16'hFF00, 16'h0001, 8'h00);
    check("model_chk", 32'(pin[9]), 32'hD8);

    // 1. Basic frame.
    acc_log.delete();
    strobe(16'h1234, 16'hFF00, 16'h0001);
    wait_idle();
    check_log_t1("basic_frame");

    // 2. Backpressure on byte 3.
    pulse_reset();
    acc_log.delete();
    strobe(16'h1234, 16'hFF00, 16'h0001);
    wait_front(4'd3);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_data", 32'(out_data), 32'h12);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    wait_idle();
    check_log_t1("bp_frame");

    // 3. Drops: one mid-frame strobe, then 300 with the link stalled.
    pulse_reset();
    acc_log.delete();
    strobe(16'h1234, 16'hFF00, 16'h0001);
    tick(); tick();
    strobe(16'h7777, 16'h8888, 16'h9999);
    wait_idle();
    check("drop_one", 32'(drop_cnt), 32'd1);
    check_log_t1("drop_frame");
    strobe(16'h0102, 16'h0304, 16'h0506);
    out_ready = 1'b0;
    sample_valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    sample_valid = 1'b0;
    check("drop_sat", 32'(drop_cnt), 32'd255);
    out_ready = 1'b1;
    wait_idle();

    // 4. Back-to-back: strobe in the cycle the checksum is accepted.
    pulse_reset();
    acc_log.delete();
    strobe(16'h1234, 16'hFF00, 16'h0001);
    for (int i = 0; i < 9; i++) tick();
    strobe(16'h0A0B, 16'h0C0D, 16'h0E0F);
    wait_idle();
    check("b2b_drop", 32'(drop_cnt), 32'd0);
    check("b2b_len", 32'(acc_log.size()), 32'd20);
    if (acc_log.size() == 20) begin
      check("b2b_sync0", 32'(acc_log[10]), 32'hA5);
      check("b2b_seq", 32'(acc_log[12]), 32'h01);
    end

    // 5. Sequence wrap over 257 frames.
    pulse_reset();
    seq_log.delete();
    for (int n = 0; n < 257; n++) begin
      strobe(16'($urandom), 16'($urandom), 16'($urandom));
      wait_idle();
    end
    check("wrap_count", 32'(seq_log.size()), 32'd257);
    if (seq_log.size() == 257) begin
      check("wrap_seq255", 32'(seq_log[255]), 32'hFF);
      check("wrap_seq256", 32'(seq_log[256]), 32'h00);
    end

    // 6a. WIDTH=12 sign extension.
    log12.delete();
    sv12 = 1'b1; ax12 = 12'hFFF; ay12 = 12'h7FF; az12 = 12'h800;
    tick();
    sv12 = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("w12_len", 32'(log12.size()), 32'd10);
    for (int k = 0; k < 10 && k < log12.size(); k++)
      check("w12_byte", 32'(log12[k]), 32'(t12_exp[k]));

    // 6b. Reset in the middle of a frame.
    strobe(16'h1111, 16'h2222, 16'h3333);
    wait_front(4'd5);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    acc_log.delete();
    strobe(16'h1234, 16'hFF00, 16'h0001);
    wait_idle();
    check_log_t1("post_rst_frame");

    // Randomized traffic with stalls and strobes at arbitrary moments.
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      sample_valid = ($urandom_range(7) == 0);
      out_ready    = ($urandom_range(3) != 0);
      ax = 16'($urandom); ay = 16'($urandom); az = 16'($urandom);
      tick();
    end
    sample_valid = 1'b0;
    out_ready    = 1'b1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
